// File: rtl/cntr_n.sv
// Loadable up/down counter FSM with a configurable double step, wrap or saturate
// arithmetic, a registered overflow pulse and combinational rail flags.
module cntr_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             load,
  input  logic             sat,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [2:0]       o_state,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StLoad = 3'b001,
    StInc  = 3'b010,
    StInc2 = 3'b011,
    StDec  = 3'b100,
    StDec2 = 3'b101
  } state_e;

  localparam logic [WIDTH:0] OneV   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] Step2V = (WIDTH + 1)'(STEP2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             ovf_q, ovf_d;
  logic             state_legal;
  logic [WIDTH:0]   step_ext, sum_up, sum_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      d_out_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_out_q <= d_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign state_legal = state_q inside {StIdle, StLoad, StInc, StInc2, StDec, StDec2};

  // A direction change always restarts at the single step.
  always_comb begin
    state_d = StIdle;
    if (!state_legal) begin
      state_d = StIdle;
    end else if (load) begin
      state_d = StLoad;
    end else if (en && inc) begin
      state_d = (state_q == StInc) ? StInc2 : StInc;
    end else if (en) begin
      state_d = (state_q == StDec) ? StDec2 : StDec;
    end
  end

  // Extra MSB of the WIDTH+1 result is the carry (up) or borrow (down).
  assign step_ext = (state_d == StInc2 || state_d == StDec2) ? Step2V : OneV;
  assign sum_up   = {1'b0, d_out_q} + step_ext;
  assign sum_dn   = {1'b0, d_out_q} - step_ext;

  always_comb begin
    d_out_d = d_out_q;
    ovf_d   = 1'b0;
    case (state_d)
      StLoad: d_out_d = d_in;
      StInc, StInc2: begin
        ovf_d   = sum_up[WIDTH];
        d_out_d = (sum_up[WIDTH] && sat) ? {WIDTH{1'b1}} : sum_up[WIDTH-1:0];
      end
      StDec, StDec2: begin
        ovf_d   = sum_dn[WIDTH];
        d_out_d = (sum_dn[WIDTH] && sat) ? {WIDTH{1'b0}} : sum_dn[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign d_out   = d_out_q;
  assign o_state = state_q;
  assign ovf     = ovf_q;
  assign at_max  = &d_out_q;
  assign at_min  = ~|d_out_q;

endmodule

// File: tb/tb_cntr_n.sv
// Directed bench for cntr_n: an 8-bit/STEP2=2 instance and a 4-bit/STEP2=3 instance
// sharing control inputs, checked against hand-computed values.
module tb_cntr_n;

  logic       clk = 1'b0;
  logic       reset, en, inc, load, sat;
  logic [7:0] d_in, d_out;
  logic [2:0] o_state;
  logic       ovf, at_max, at_min;
  logic [3:0] d_in4, d_out4;
  logic [2:0] o_state4;
  logic       ovf4, at_max4, at_min4;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2:0] st_up [4] = '{3'b010, 3'b011, 3'b010, 3'b011};
  logic [7:0] d_up  [4] = '{8'd1, 8'd3, 8'd4, 8'd6};
  logic [2:0] st_dn [4] = '{3'b100, 3'b101, 3'b100, 3'b101};
  logic [7:0] d_dn  [4] = '{8'd5, 8'd3, 8'd2, 8'd0};

  always #5 clk = ~clk;

  cntr_n #(.WIDTH(8), .STEP2(2)) dut (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .load(load), .sat(sat),
    .d_in(d_in), .d_out(d_out), .o_state(o_state), .ovf(ovf),
    .at_max(at_max), .at_min(at_min)
  );

  cntr_n #(.WIDTH(4), .STEP2(3)) dut4 (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .load(load), .sat(sat),
    .d_in(d_in4), .d_out(d_out4), .o_state(o_state4), .ovf(ovf4),
    .at_max(at_max4), .at_min(at_min4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; inc = 1'b0; load = 1'b0; sat = 1'b0;
    d_in = 8'h00; d_in4 = 4'h0;
    #2;
    check("rst_d_out", 32'(d_out), 32'h0);
    check("rst_state", 32'(o_state), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_at_min", 32'(at_min), 32'h1);
    check("rst_at_max", 32'(at_max), 32'h0);

    @(negedge clk);
    reset = 1'b0; en = 1'b1; inc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("up_state", 32'(o_state), 32'(st_up[i]));
      check("up_d_out", 32'(d_out), 32'(d_up[i]));
      check("up_ovf", 32'(ovf), 32'h0);
    end
    inc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dn_state", 32'(o_state), 32'(st_dn[i]));
      check("dn_d_out", 32'(d_out), 32'(d_dn[i]));
      check("dn_ovf", 32'(ovf), 32'h0);
    end
    check("dn_at_min", 32'(at_min), 32'h1);

    // Wrap upward
    load = 1'b1; d_in = 8'hFE; tick();
    check("wrap_up_load", 32'(d_out), 32'hFE);
    load = 1'b0; en = 1'b1; inc = 1'b1; sat = 1'b0; tick();
    check("wrap_up_ff", 32'(d_out), 32'hFF);
    check("wrap_up_at_max", 32'(at_max), 32'h1);
    check("wrap_up_ovf0", 32'(ovf), 32'h0);
    tick();
    check("wrap_up_01", 32'(d_out), 32'h01);
    check("wrap_up_ovf1", 32'(ovf), 32'h1);
    en = 1'b0; tick();
    check("wrap_up_idle_d", 32'(d_out), 32'h01);
    check("wrap_up_idle_ovf", 32'(ovf), 32'h0);

    // Saturate upward, clamps repeat at the rail
    load = 1'b1; d_in = 8'hFE; sat = 1'b1; tick();
    check("sat_up_load", 32'(d_out), 32'hFE);
    load = 1'b0; en = 1'b1; inc = 1'b1; tick();
    check("sat_up_ff", 32'(d_out), 32'hFF);
    check("sat_up_ovf0", 32'(ovf), 32'h0);
    tick();
    check("sat_up_clamp", 32'(d_out), 32'hFF);
    check("sat_up_ovf1", 32'(ovf), 32'h1);
    tick();
    check("sat_up_clamp2", 32'(d_out), 32'hFF);
    check("sat_up_ovf2", 32'(ovf), 32'h1);

    // Wrap downward
    load = 1'b1; d_in = 8'h01; sat = 1'b0; tick();
    load = 1'b0; inc = 1'b0; tick();
    check("wrap_dn_00", 32'(d_out), 32'h00);
    check("wrap_dn_ovf0", 32'(ovf), 32'h0);
    tick();
    check("wrap_dn_fe", 32'(d_out), 32'hFE);
    check("wrap_dn_ovf1", 32'(ovf), 32'h1);

    // Saturate downward
    load = 1'b1; d_in = 8'h01; sat = 1'b1; tick();
    load = 1'b0; tick();
    check("sat_dn_00", 32'(d_out), 32'h00);
    check("sat_dn_ovf0", 32'(ovf), 32'h0);
    tick();
    check("sat_dn_clamp", 32'(d_out), 32'h00);
    check("sat_dn_ovf1", 32'(ovf), 32'h1);

    // Load beats count enable
    load = 1'b1; en = 1'b1; inc = 1'b1; d_in = 8'h10; sat = 1'b0; tick();
    check("prio_state", 32'(o_state), 32'h1);
    check("prio_d_out", 32'(d_out), 32'h10);
    load = 1'b0; tick();
    check("prio_inc_state", 32'(o_state), 32'h2);
    check("prio_inc_d", 32'(d_out), 32'h11);
    en = 1'b0; tick();
    check("prio_idle_state", 32'(o_state), 32'h0);
    check("prio_idle_d", 32'(d_out), 32'h11);

    // Asynchronous reset mid-count
    load = 1'b1; d_in = 8'h3D; tick();
    load = 1'b0; en = 1'b1; inc = 1'b1; tick(); tick();
    check("pre_rst_state", 32'(o_state), 32'h3);
    check("pre_rst_d", 32'(d_out), 32'h40);
    #2 reset = 1'b1;
    #1;
    check("async_rst_d", 32'(d_out), 32'h0);
    check("async_rst_state", 32'(o_state), 32'h0);
    check("async_rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    reset = 1'b0; tick();
    check("post_rst_state", 32'(o_state), 32'h2);
    check("post_rst_d", 32'(d_out), 32'h01);

    // 4-bit instance, STEP2=3
    en = 1'b0; load = 1'b1; d_in4 = 4'hE; tick();
    check("w4_load", 32'(d_out4), 32'hE);
    load = 1'b0; en = 1'b1; inc = 1'b1; sat = 1'b0; tick();
    check("w4_inc", 32'(d_out4), 32'hF);
    check("w4_at_max", 32'(at_max4), 32'h1);
    check("w4_ovf0", 32'(ovf4), 32'h0);
    tick();
    check("w4_inc2_state", 32'(o_state4), 32'h3);
    check("w4_inc2_d", 32'(d_out4), 32'h2);
    check("w4_inc2_ovf", 32'(ovf4), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cntr_n.md
Name: cntr_n

Overview:
- Parametrised successor to the team's 8-bit load/inc/dec counter FSM.
- Generalises the counter width and the alternate step size, and adds a count enable, a wrap/saturate mode, an overflow pulse and min/max flags.
- Used as a general-purpose loadable up/down counter with state visibility for debug and sequencing logic.

Parameters:
- WIDTH, 8: counter width in bits; legal range ≥2.
- STEP2, 2: step size applied in the INC2/DEC2 states; legal range 1 to 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; when 0 and load=0 the FSM goes to IDLE and holds d_out.
- inc  input  1  direction: 1 = count up, 0 = count down (only used when en=1).
- load  input  1  synchronous load of d_in; highest priority after reset.
- sat  input  1  arithmetic mode: 0 = wrap modulo 2^WIDTH, 1 = saturate at 0 / 2^WIDTH-1.
- d_in  input  WIDTH  load value.
- d_out  output  WIDTH  registered count.
- o_state  output  3  registered FSM state.
- ovf  output  1  registered one-cycle pulse; set when the update just performed wrapped or clamped.
- at_max  output  1  combinational; d_out == 2^WIDTH-1.
- at_min  output  1  combinational; d_out == 0.

Behaviour:
- Reset (asynchronous, immediate, any time incl. mid-count):
  - d_out=0, o_state=IDLE, ovf=0.
  - The first clock edge after reset deassertion evaluates the inputs normally.
- State encoding: IDLE=3'b000, LOAD=3'b001, INC=3'b010, INC2=3'b011, DEC=3'b100, DEC2=3'b101. Codes 110/111 are unreachable; if entered, the next state is IDLE and d_out is held.
- Next-state priority, evaluated each rising edge:
  1. load=1 -> LOAD.
  2. en=1, inc=1 -> INC2 if current state is INC, else INC.
  3. en=1, inc=0 -> DEC2 if current state is DEC, else DEC.
  4. en=0 -> IDLE.
- Up and down sequences never interleave: any direction change restarts at the single step (INC or DEC).
- d_out is updated on the same edge the state is entered (latency 1 clock from inputs to d_out/o_state):
  - LOAD: d_out=d_in, ovf=0.
  - INC: +1. INC2: +STEP2.
  - DEC: -1. DEC2: -STEP2.
  - IDLE: hold, ovf=0.
- Arithmetic is computed at WIDTH+1 bits.
  - sat=0: result truncated to WIDTH bits (wrap); ovf=1 if carry or borrow occurred.
  - sat=1: result clamped to 2^WIDTH-1 on overflow or 0 on underflow; ovf=1 only if clamping changed the result.
  - A step that lands exactly on 0 or max is not an overflow: ovf=0.
- ovf is a one-cycle pulse per offending update. Consecutive clamps at a rail give consecutive ovf=1 cycles.
- at_max/at_min are derived from d_out only (no extra latency).
- sat and d_in are sampled only on the edge that uses them; mode changes take effect on the next update.

Test Plan:
- Reset, then en=1, inc=1 for 4 clocks -> o_state 010,011,010,011; d_out 1,3,4,6; ovf=0 throughout.
- Continue with inc=0 for 4 clocks -> o_state 100,101,100,101; d_out 5,3,2,0; at_min=1 after the last edge, ovf=0.
- load=1, d_in=8'hFE, then load=0, en=1, inc=1, sat=0 for 2 clocks -> d_out FE, FF (at_max=1), 01 with ovf=1 for exactly one cycle. Same with sat=1 -> FE, FF, FF with ovf=1 on the third edge only.
- load d_in=8'h01, then inc=0, sat=0 for 2 clocks -> d_out 00 (ovf=0), FE (ovf=1). Same with sat=1 -> 00, 00 (ovf=1).
- Priority: load=1 with en=1, inc=1, d_in=8'h10 -> o_state=001, d_out=10. Next edge with load=0 -> INC, d_out=11. en=0 -> IDLE, d_out holds 11.
- Assert reset between clock edges while in INC2 with d_out=8'h40 -> d_out=0, o_state=000, ovf=0 immediately, without waiting for a clock edge. Deassert, en=1, inc=1 -> next edge INC, d_out=1. Repeat the sequence test at WIDTH=4, STEP2=3: from 4'hE, INC/INC2 gives F, 2 with ovf=1.
